// File: rtl/m3_step_rate_ctrl.sv
// Commutation step sequencer with ramped step period and power level.
// Drives step index, step strobe, period and power to the PWM path.
module m3_step_rate_ctrl #(
  parameter int PERIOD_W    = 22,
  parameter int PERIOD_MAX  = 4000000,
  parameter int PERIOD_MIN  = 40,
  parameter int RAMP_SHIFT  = 4,
  parameter int STEPS       = 12,
  parameter int STEP_W      = 4,
  parameter int POWER_W     = 8,
  parameter int POWER_MAX   = 255,
  parameter int POWER_INIT  = 64,
  parameter int POWER_DELTA = 8
) (
  input  logic                clkI,
  input  logic                rstI,
  input  logic                m3startI,
  input  logic                m3forceStopI,
  input  logic                m3invRotateI,
  input  logic                m3freqINCi,
  input  logic                m3freqDECi,
  input  logic                m3powerINCi,
  input  logic                m3powerDECi,
  output logic [STEP_W-1:0]   stepO,
  output logic                stepValidO,
  output logic                runO,
  output logic [PERIOD_W-1:0] periodO,
  output logic [POWER_W-1:0]  powerO
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_e;

  localparam logic [PERIOD_W-1:0] PMAX =
    PERIOD_W'(PERIOD_MAX);
  localparam logic [PERIOD_W-1:0] PMIN =
    PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W:0] PMAX_X =
    (PERIOD_W+1)'(PERIOD_MAX);
  localparam logic [PERIOD_W:0] PMIN_X =
    (PERIOD_W+1)'(PERIOD_MIN);
  localparam logic [POWER_W-1:0] WMAX =
    POWER_W'(POWER_MAX);
  localparam logic [POWER_W-1:0] WINIT =
    POWER_W'(POWER_INIT);
  localparam logic [POWER_W-1:0] WDELTA =
    POWER_W'(POWER_DELTA);
  localparam logic [POWER_W:0] WMAX_X =
    (POWER_W+1)'(POWER_MAX);
  localparam logic [STEP_W-1:0] SLAST =
    STEP_W'(STEPS-1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                valid_q, valid_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] remain_q, remain_d;
  logic [POWER_W-1:0]  power_q, power_d;
  logic                done_q, done_d;

  logic [PERIOD_W-1:0] delta;
  logic [PERIOD_W:0]   p_up, p_lo;
  logic [PERIOD_W-1:0] p_slow, p_fast;
  logic [POWER_W:0]    w_up;
  logic [POWER_W-1:0]  w_inc, w_dec;
  logic [STEP_W-1:0]   s_fwd, s_rev;
  logic                tick, idle_go;

  always_comb begin
    delta = period_q >> RAMP_SHIFT;
    if (delta == '0) delta = PERIOD_W'(1);
    p_up = {1'b0, period_q} + {1'b0, delta};
    p_lo = PMIN_X + {1'b0, delta};
    p_slow = (p_up > PMAX_X) ? PMAX
           : p_up[PERIOD_W-1:0];
    p_fast = ({1'b0, period_q} < p_lo) ? PMIN
           : period_q - delta;
    w_up = {1'b0, power_q} + {1'b0, WDELTA};
    w_inc = (w_up > WMAX_X) ? WMAX
          : w_up[POWER_W-1:0];
    w_dec = (power_q < WDELTA) ? '0
          : power_q - WDELTA;
    s_fwd = (step_q == SLAST) ? '0
          : step_q + STEP_W'(1);
    s_rev = (step_q == '0) ? SLAST
          : step_q - STEP_W'(1);
  end

  assign tick = (remain_q == PERIOD_W'(1));
  assign idle_go = m3forceStopI ||
    (state_q == STOPPING && done_q);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    valid_d  = 1'b0;
    period_d = period_q;
    remain_d = remain_q;
    power_d  = power_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m3startI) begin
          state_d  = RUN;
          step_d   = '0;
          valid_d  = 1'b1;
          remain_d = period_q;
          power_d  = WINIT;
        end
      end
      RUN, STOPPING: begin
        remain_d = remain_q - PERIOD_W'(1);
        if (tick) begin
          step_d   = m3invRotateI ? s_rev : s_fwd;
          valid_d  = 1'b1;
          remain_d = period_q;
        end
        if (m3powerINCi && !m3powerDECi)
          power_d = w_inc;
        else if (m3powerDECi && !m3powerINCi)
          power_d = w_dec;
        if (state_q == RUN) begin
          if (m3freqINCi && !m3freqDECi)
            period_d = p_fast;
          else if (m3freqDECi && !m3freqINCi)
            period_d = p_slow;
          if (!m3startI) state_d = STOPPING;
        end else begin
          // decel: stretch period at each advance
          if (tick) begin
            period_d = p_slow;
            remain_d = p_slow;
            done_d   = (period_q == PMAX);
          end
          if (m3startI) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (idle_go) begin
      state_d  = IDLE;
      step_d   = '0;
      valid_d  = 1'b0;
      period_d = PMAX;
      remain_d = PMAX;
      power_d  = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      state_q  <= IDLE;
      step_q   <= '0;
      valid_q  <= 1'b0;
      period_q <= PMAX;
      remain_q <= PMAX;
      power_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      valid_q  <= valid_d;
      period_q <= period_d;
      remain_q <= remain_d;
      power_q  <= power_d;
      done_q   <= done_d;
    end
  end

  assign stepO      = step_q;
  assign stepValidO = valid_q;
  assign runO       = (state_q != IDLE);
  assign periodO    = period_q;
  assign powerO     = power_q;

endmodule

// File: tb/tb_m3_step_rate_ctrl.sv
// Directed bench for m3_step_rate_ctrl with a
// 400-clock slow period, 40 fast, 12 steps.
module tb_m3_step_rate_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        force_stop = 1'b0;
  logic        inv = 1'b0;
  logic        finc = 1'b0;
  logic        fdec = 1'b0;
  logic        pinc = 1'b0;
  logic        pdec = 1'b0;
  logic [3:0]  step;
  logic        valid;
  logic        run;
  logic [21:0] period;
  logic [7:0]  power;

  int checks = 0;
  int failures = 0;
  int n;

  m3_step_rate_ctrl #(
    .PERIOD_MAX(400),
    .PERIOD_MIN(40),
    .RAMP_SHIFT(4),
    .STEPS(12)
  ) dut (
    .clkI(clk),
    .rstI(rst),
    .m3startI(start),
    .m3forceStopI(force_stop),
    .m3invRotateI(inv),
    .m3freqINCi(finc),
    .m3freqDECi(fdec),
    .m3powerINCi(pinc),
    .m3powerDECi(pdec),
    .stepO(step),
    .stepValidO(valid),
    .runO(run),
    .periodO(period),
    .powerO(power)
  );

  always #5 clk = ~clk;

  task automatic tk(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!valid && cnt < 2000);
    if (!valid) begin
      checks++;
      failures++;
      $error("FAIL valid_timeout observed=%0d expected=1",
             valid);
    end
  endtask

  task automatic pulse_finc();
    finc = 1'b1; tk(1); finc = 1'b0;
  endtask

  task automatic pulse_pinc();
    pinc = 1'b1; tk(1); pinc = 1'b0;
  endtask

  task automatic pulse_pdec();
    pdec = 1'b1; tk(1); pdec = 1'b0;
  endtask

  initial begin
    // reset state
    tk(3);
    rst = 1'b0;
    tk(1);
    chk("rst_step", step, 0);
    chk("rst_period", period, 400);
    chk("rst_power", power, 0);
    chk("rst_run", run, 0);
    chk("rst_valid", valid, 0);

    // idle ignores ramp / power pulses
    pulse_finc();
    pulse_pinc();
    chk("idle_period", period, 400);
    chk("idle_power", power, 0);

    // start, forward stepping
    start = 1'b1;
    tk(1);
    chk("start_run", run, 1);
    chk("start_valid", valid, 1);
    chk("start_step", step, 0);
    chk("start_power", power, 64);
    tk(1);
    chk("valid_once", valid, 0);
    wait_valid(n);
    chk("first_interval", n + 1, 400);
    chk("step1", step, 1);

    fdec = 1'b1; tk(1); fdec = 1'b0;
    chk("dec_at_max", period, 400);
    finc = 1'b1; fdec = 1'b1; tk(1);
    finc = 1'b0; fdec = 1'b0;
    chk("incdec_period", period, 400);
    wait_valid(n);
    chk("second_interval", n + 2, 400);
    chk("step2", step, 2);

    for (int i = 0; i < 9; i++) wait_valid(n);
    chk("step11", step, 11);
    wait_valid(n);
    chk("wrap_step0", step, 0);

    // ramp up frequency
    pulse_finc();
    chk("inc_375", period, 375);
    wait_valid(n);
    chk("interval_old", n + 1, 400);
    wait_valid(n);
    chk("interval_375", n, 375);
    for (int i = 0; i < 80; i++) begin
      pulse_finc();
      tk(1);
    end
    chk("inc_sat_min", period, 40);
    finc = 1'b1; fdec = 1'b1; tk(1);
    finc = 1'b0; fdec = 1'b0;
    chk("incdec_min", period, 40);
    wait_valid(n);
    wait_valid(n);
    chk("interval_40", n, 40);

    // power saturation
    for (int i = 0; i < 23; i++) begin
      pulse_pinc();
      tk(1);
    end
    chk("power_248", power, 248);
    pulse_pinc();
    chk("power_sat", power, 255);
    pinc = 1'b1; pdec = 1'b1; tk(1);
    pinc = 1'b0; pdec = 1'b0;
    chk("power_incdec", power, 255);
    for (int i = 0; i < 40; i++) begin
      pulse_pdec();
      tk(1);
    end
    chk("power_floor", power, 0);
    pulse_pinc();
    pulse_pinc();
    chk("power_16", power, 16);

    // graceful stop from period 40
    wait_valid(n);
    start = 1'b0;
    wait_valid(n);
    chk("stop_int40", n, 40);
    chk("stop_run", run, 1);
    wait_valid(n);
    chk("stop_int42", n, 42);
    wait_valid(n);
    chk("stop_int44", n, 44);
    chk("stop_per46", period, 46);

    // resume during deceleration
    start = 1'b1;
    tk(1);
    chk("resume_run", run, 1);
    chk("resume_period", period, 46);
    chk("resume_power", power, 16);
    wait_valid(n);
    chk("resume_int", n + 1, 46);

    // stop all the way to idle
    start = 1'b0;
    n = 0;
    while (run && n < 20000) begin
      tk(1);
      n++;
    end
    chk("stop_idle_run", run, 0);
    chk("stop_idle_power", power, 0);
    chk("stop_idle_period", period, 400);
    chk("stop_idle_step", step, 0);

    // reverse rotation
    inv = 1'b1;
    start = 1'b1;
    tk(1);
    chk("rev_start", step, 0);
    chk("rev_power", power, 64);
    wait_valid(n);
    chk("rev_step11", step, 11);
    wait_valid(n);
    chk("rev_step10", step, 10);
    tk(100);
    inv = 1'b0;
    tk(100);
    inv = 1'b1;
    wait_valid(n);
    chk("rev_step9", step, 9);
    tk(10);
    inv = 1'b0;
    wait_valid(n);
    chk("fwd_step10", step, 10);

    // force stop mid-interval
    pulse_pinc();
    pulse_finc();
    chk("pre_force_pw", power, 72);
    chk("pre_force_per", period, 375);
    tk(10);
    force_stop = 1'b1;
    start = 1'b0;
    tk(1);
    chk("fs_run", run, 0);
    chk("fs_power", power, 0);
    chk("fs_period", period, 400);
    chk("fs_step", step, 0);
    chk("fs_valid", valid, 0);
    force_stop = 1'b0;
    tk(1);
    chk("fs_idle", run, 0);
    start = 1'b1;
    tk(1);
    chk("fs_restart_valid", valid, 1);
    chk("fs_restart_pw", power, 64);
    chk("fs_restart_per", period, 400);

    // reset mid-interval
    tk(50);
    rst = 1'b1;
    tk(1);
    chk("rs_run", run, 0);
    chk("rs_power", power, 0);
    chk("rs_step", step, 0);
    chk("rs_valid", valid, 0);
    rst = 1'b0;
    tk(1);
    chk("rs_restart_valid", valid, 1);
    chk("rs_restart_pw", power, 64);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/m3_step_rate_ctrl.md
# m3_step_rate_ctrl

Parametrised commutation-step and drive-level controller for the 3-phase motor path. It sits between the front-panel/command inputs and the PWM/sine generator. It sequences a wrap-around step index at a programmable period, and ramps that period with frequency INC/DEC commands. It holds a saturating power level and supports forward/reverse rotation, a graceful deceleration stop and a hard force-stop.

## Interface
Parameters:
- PERIOD_W, 22, width of period/remain counters
- PERIOD_MAX, 4000000, slowest step period in clocks; also the idle period
- PERIOD_MIN, 40, fastest step period in clocks
- RAMP_SHIFT, 4, period delta per ramp event = max(period >> RAMP_SHIFT, 1)
- STEPS, 12, steps per electrical revolution (≥2)
- STEP_W, 4, width of stepO (≥ clog2(STEPS))
- POWER_W, 8, width of powerO
- POWER_MAX, 255, power saturation ceiling
- POWER_INIT, 64, power loaded on IDLE→RUN
- POWER_DELTA, 8, power change per INC/DEC pulse

Ports:
- clkI in 1: single clock; all logic on rising edge
- rstI in 1: reset, synchronous, active-high
- m3startI in 1: level; high = run request
- m3forceStopI in 1: level; high = immediate stop, overrides everything except reset
- m3invRotateI in 1: 0 = step increments, 1 = step decrements
- m3freqINCi / m3freqDECi in 1: single-cycle pulses; INC shortens period, DEC lengthens it
- m3powerINCi / m3powerDECi in 1: single-cycle pulses
- stepO out STEP_W: current step, 0..STEPS-1
- stepValidO out 1: one-cycle pulse whenever stepO is (re)loaded
- runO out 1: high in RUN or STOPPING
- periodO out PERIOD_W: current step period
- powerO out POWER_W: current power level

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE:
  - stepO=0, periodO=PERIOD_MAX, powerO=0, runO=0.
  - INC/DEC inputs ignored.
- IDLE→RUN when m3startI=1 and m3forceStopI=0.
  - On entry: stepO=0, stepValidO=1, remain=periodO, powerO=POWER_INIT.
  - periodO keeps its value (PERIOD_MAX after idle).
- RUN:
  - remain decrements each cycle.
  - When remain==1:
    - Advance the step and reload remain with the current periodO.
    - Pulse stepValidO.
    - Forward wraps STEPS-1→0; reverse wraps 0→STEPS-1.
    - m3invRotateI is sampled only at the advance.
- Period ramp, RUN only:
  - freqINC: periodO = max(periodO − d, PERIOD_MIN).
  - freqDEC: periodO = min(periodO + d, PERIOD_MAX).
  - d = max(periodO>>RAMP_SHIFT, 1).
  - The new period takes effect at the next reload; the running remain is untouched.
- Power, RUN and STOPPING:
  - INC: min(powerO+POWER_DELTA, POWER_MAX).
  - DEC: max(powerO−POWER_DELTA, 0), computed without underflow.
- Simultaneous INC and DEC of the same quantity: no change.
- RUN→STOPPING when m3startI=0.
  - Steps keep advancing.
  - At each step advance, periodO grows by d (saturating at PERIOD_MAX); freq pulses are ignored.
  - When a step advance occurs with periodO==PERIOD_MAX, go to IDLE on the next cycle.
- STOPPING→RUN when m3startI=1. Current periodO, stepO and powerO are kept; powerO is not reloaded.
- m3forceStopI=1 in any state: next cycle IDLE with IDLE output values. No stepValidO pulse.
- Reset: same values as IDLE, stepValidO=0.
- Arithmetic: all sums are done one bit wider than PERIOD_W/POWER_W before saturation. No wrap-around on period or power.

## Timing
- All outputs are registered.
- m3startI asserted in cycle N (from IDLE) → runO=1, stepValidO=1, stepO=0 in cycle N+1.
- First step advance is P cycles later, where P = periodO at entry. Steady state gives one stepValidO every periodO cycles.
- Freq/power pulse in cycle N → periodO/powerO updated in cycle N+1.
- m3forceStopI in cycle N → runO=0, powerO=0 in cycle N+1.
- m3startI deasserted in RUN at cycle N → STOPPING in cycle N+1. The step cadence is not interrupted.
- Reset mid-operation → all outputs at reset values in the cycle after rstI is sampled high.

## Test plan
Params for all scenarios: PERIOD_MAX=400, PERIOD_MIN=40, RAMP_SHIFT=4, STEPS=12.
- Start, forward: start at cycle 10 → stepValidO at 11 (step 0), 411 (step 1), 811 (step 2). After 12 advances stepO wraps 11→0.
- Ramp:
  - One freqINC at 400 → periodO=375; the next interval is 375 cycles.
  - Repeated INC → periodO saturates at 40.
  - freqDEC at 400 → stays 400.
  - Simultaneous INC+DEC → unchanged.
- Reverse: m3invRotateI=1 from step 0 → next steps are 11, 10. Toggling mid-interval takes effect only at the next advance.
- Power:
  - Entry → 64.
  - 24 INC pulses → 255 (saturated).
  - 40 DEC pulses → 0, with no underflow.
  - INC+DEC together → unchanged.
- Graceful stop: period 40, drop m3startI.
  - Each subsequent interval grows by max(p>>4, 1).
  - Reach 400 → IDLE, runO=0, powerO=0.
  - Re-assert start during STOPPING → RUN with period and power kept.
- Force-stop / reset: m3forceStopI or rstI mid-interval → next cycle stepO=0, periodO=400, powerO=0, runO=0, no stepValidO. The next start re-enters as a fresh start.
